// File: rtl/tt_input_conditioner_if.sv
// Signal bundle between the raw input pins and the input-conditioning stage.
// The master side drives the enable and raw pins; the slave side (the
// conditioner) returns the clean levels and edge strobes.
interface tt_input_conditioner_if #(
   parameter int unsigned WIDTH = 8
);
   logic             ena;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             changed;

   modport master (
      output ena,
      output din,
      input  dout,
      input  rise,
      input  fall,
      input  changed
   );

   modport slave (
      input  ena,
      input  din,
      output dout,
      output rise,
      output fall,
      output changed
   );
endinterface

// File: rtl/tt_input_conditioner.sv
// Input conditioner: per-bit synchroniser, debounce counter and registered
// rise/fall/changed strobes. Every output comes straight from a flop, so no
// combinational path exists from din to the outputs.
module tt_input_conditioner #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,   // 2 or 3
   parameter int unsigned DB_CYCLES   = 4    // 1..255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tt_input_conditioner_if.slave io
);

   localparam int unsigned    CW       = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;

   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         dout_q, dout_d;
   logic [WIDTH-1:0]         rise_q, rise_d;
   logic [WIDTH-1:0]         fall_q, fall_d;
   logic                     changed_q, changed_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: shifts every clock, independent of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= io.din;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Per-bit debounce: accept a new level after DB_CYCLES consecutive mismatches.
   always_comb begin
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      rise_d    = '0;
      fall_d    = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!io.ena) begin
            cnt_d[i] = '0;
         end else if (s[i] == dout_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            dout_d[i] = s[i];
            cnt_d[i]  = '0;
            rise_d[i] = s[i];
            fall_d[i] = ~s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   // State and strobe registers; strobes land one cycle with the new dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         dout_q    <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign io.dout    = dout_q;
   assign io.rise    = rise_q;
   assign io.fall    = fall_q;
   assign io.changed = changed_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Directed bench for tt_input_conditioner with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_tt_input_conditioner;

   localparam int unsigned WIDTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   tt_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

   tt_input_conditioner #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .DB_CYCLES   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                      input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f,
                             input logic c);
      chk({tag, ".dout"}, bus.dout, d);
      chk({tag, ".rise"}, bus.rise, r);
      chk({tag, ".fall"}, bus.fall, f);
      chk({tag, ".changed"}, {{(WIDTH-1){1'b0}}, bus.changed}, {{(WIDTH-1){1'b0}}, c});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ena = 1'b0;
      bus.din = '0;

      // reset asserted asynchronously at time 0
      rst_n = 1'b0;
      #1;
      expect_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
      step(); step(); step();
      expect_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
      rst_n   = 1'b1;
      bus.ena = 1'b1;

      // quiet input for 20 cycles
      for (int k = 0; k < 20; k++) begin
         step();
         expect_all("idle", 8'h00, 8'h00, 8'h00, 1'b0);
      end

      // single-bit rise: dout updates at E0+5
      bus.din = 8'h01;
      for (int k = 0; k < 5; k++) begin
         step();
         expect_all("rise0_wait", 8'h00, 8'h00, 8'h00, 1'b0);
      end
      step();
      expect_all("rise0_hit", 8'h01, 8'h01, 8'h00, 1'b1);
      step();
      expect_all("rise0_after", 8'h01, 8'h00, 8'h00, 1'b0);

      // and back down
      bus.din = 8'h00;
      for (int k = 0; k < 5; k++) begin
         step();
         expect_all("fall0_wait", 8'h01, 8'h00, 8'h00, 1'b0);
      end
      step();
      expect_all("fall0_hit", 8'h00, 8'h00, 8'h01, 1'b1);
      step();
      expect_all("fall0_after", 8'h00, 8'h00, 8'h00, 1'b0);

      // 3-cycle glitch on bit 3 is rejected
      bus.din = 8'h08;
      step(); step(); step();
      bus.din = 8'h00;
      for (int k = 0; k < 10; k++) begin
         step();
         expect_all("glitch3", 8'h00, 8'h00, 8'h00, 1'b0);
      end

      // 4-cycle pulse on bit 3 is accepted, then falls again
      bus.din = 8'h08;
      step(); step(); step(); step();                 // E0..E0+3
      bus.din = 8'h00;
      step();                                         // E0+4
      expect_all("pulse4_pre", 8'h00, 8'h00, 8'h00, 1'b0);
      step();                                         // E0+5
      expect_all("pulse4_rise", 8'h08, 8'h08, 8'h00, 1'b1);
      for (int k = 0; k < 3; k++) begin               // E0+6..E0+8
         step();
         expect_all("pulse4_hold", 8'h08, 8'h00, 8'h00, 1'b0);
      end
      step();                                         // E0+9
      expect_all("pulse4_fall", 8'h00, 8'h00, 8'h08, 1'b1);
      step();
      expect_all("pulse4_after", 8'h00, 8'h00, 8'h00, 1'b0);

      // multi-bit simultaneous rise
      bus.din = 8'hA5;
      for (int k = 0; k < 5; k++) step();
      expect_all("a5_pre", 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      expect_all("a5_hit", 8'hA5, 8'hA5, 8'h00, 1'b1);
      step();
      expect_all("a5_after", 8'hA5, 8'h00, 8'h00, 1'b0);

      // bring dout to FF (remaining bits rise)
      bus.din = 8'hFF;
      for (int k = 0; k < 5; k++) step();
      step();
      expect_all("ff_hit", 8'hFF, 8'h5A, 8'h00, 1'b1);
      step();
      expect_all("ff_after", 8'hFF, 8'h00, 8'h00, 1'b0);

      // ena low: dout holds, no strobes; full latency after re-enable
      bus.din = 8'h00;
      bus.ena = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         expect_all("ena_off", 8'hFF, 8'h00, 8'h00, 1'b0);
      end
      bus.ena = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         expect_all("ena_restart", 8'hFF, 8'h00, 8'h00, 1'b0);
      end
      step();
      expect_all("ena_fall", 8'h00, 8'h00, 8'hFF, 1'b1);
      step();
      expect_all("ena_after", 8'h00, 8'h00, 8'h00, 1'b0);

      // reset in the middle of a pending rise
      bus.din = 8'h0F;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      expect_all("midrst_async", 8'h00, 8'h00, 8'h00, 1'b0);
      step(); step();
      expect_all("midrst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         expect_all("midrst_wait", 8'h00, 8'h00, 8'h00, 1'b0);
      end
      step();
      expect_all("midrst_rise", 8'h0F, 8'h0F, 8'h00, 1'b1);

      // asynchronous reset while dout and strobes are set, away from any edge
      #2;
      rst_n = 1'b0;
      #1;
      expect_all("async_clear", 8'h00, 8'h00, 8'h00, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      expect_all("post_clear", 8'h00, 8'h00, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
